// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module : mc_ctrl_pkg
// Brief  : State, control-word and opcode definitions for the multicycle
//          MIPS main controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        IMM_EXEC  = 4'd8,
        IMM_WB    = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JAL_LINK  = 4'd12,
        FAULT     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        OPK_RTYPE   = 4'd0,
        OPK_LW      = 4'd1,
        OPK_SW      = 4'd2,
        OPK_BEQ     = 4'd3,
        OPK_BNE     = 4'd4,
        OPK_J       = 4'd5,
        OPK_JAL     = 4'd6,
        OPK_ADDI    = 4'd7,
        OPK_ANDI    = 4'd8,
        OPK_ORI     = 4'd9,
        OPK_ILLEGAL = 4'd10
    } op_kind_t;

    // rdy_gate: ir_write/pc_write/retire only count in a cycle with mem_ready.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       reg_write;
        logic       branch;
        logic       branch_ne;
        logic       imm_zext;
        logic       link;
        logic       retire;
        logic       rdy_gate;
        logic       fault;
    } ctrl_word_t;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_logic = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    localparam logic [1:0] c_srcb_reg    = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_branch = 2'b11;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    function automatic op_kind_t decode_op(input logic [5:0] op);
        op_kind_t k;
        case (op)
            c_op_rtype: k = OPK_RTYPE;
            c_op_j:     k = OPK_J;
            c_op_jal:   k = OPK_JAL;
            c_op_beq:   k = OPK_BEQ;
            c_op_bne:   k = OPK_BNE;
            c_op_addi:  k = OPK_ADDI;
            c_op_andi:  k = OPK_ANDI;
            c_op_ori:   k = OPK_ORI;
            c_op_lw:    k = OPK_LW;
            c_op_sw:    k = OPK_SW;
            default:    k = OPK_ILLEGAL;
        endcase
        return k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module : mc_wait_timer
// Brief  : Saturating wait-state counter with timeout flag; LIMIT = 0 never
//          times out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int c_cnt_w = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_max  = '1;
    localparam logic [c_cnt_w-1:0] c_last = (LIMIT == 0) ? '0 : c_cnt_w'(LIMIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    // Flag fires in the cycle whose missing ready would make the count reach LIMIT.
    generate
        if (LIMIT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timeout
            assign timeout = inc && (r_count >= c_last);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_controller_fsm.sv
// ============================================================================
// Module : mc_controller_fsm
// Brief  : Multicycle MIPS main controller with memory handshake, wait
//          timeout, illegal-opcode fault and retire pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_controller_fsm #(
    parameter int OP_W         = 6,
    parameter int TIMEOUT_CYC  = 16,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [OP_W-1:0] op_i6,
    input  logic            mem_ready_i,
    output logic            mem_req_o,
    output logic            mem_to_reg_o,
    output logic            reg_dst_rtrd_o,
    output logic            instr_or_data_o,
    output logic            a_alu_input_o,
    output logic [1:0]      pc_branch_o2,
    output logic [1:0]      b_alu_input_o2,
    output logic [1:0]      alu_alt_ctrl_o2,
    output logic            instr_we_o,
    output logic            enable_wmem_o,
    output logic            pc_write_o,
    output logic            enable_wrf_o,
    output logic            branch_o,
    output logic            branch_ne_o,
    output logic            imm_zext_o,
    output logic            link_o,
    output logic            retire_o,
    output logic            fault_o,
    output logic [3:0]      state_o4
);

    import mc_ctrl_pkg::*;

    function automatic ctrl_word_t ctrl_decode(input state_t s, input op_kind_t k);
        ctrl_word_t w;
        w = '0;
        case (s)
            FETCH: begin
                w.mem_req   = 1'b1;
                w.alu_src_b = c_srcb_four;
                w.ir_write  = 1'b1;
                w.pc_write  = 1'b1;
                w.rdy_gate  = 1'b1;
            end
            DECODE: begin
                w.alu_src_b = c_srcb_branch;
            end
            MEM_ADR: begin
                w.alu_src_a = 1'b1;
                w.alu_src_b = c_srcb_imm;
            end
            MEM_READ: begin
                w.iord    = 1'b1;
                w.mem_req = 1'b1;
            end
            MEM_WRITE: begin
                w.iord      = 1'b1;
                w.mem_req   = 1'b1;
                w.mem_write = 1'b1;
                w.retire    = 1'b1;
                w.rdy_gate  = 1'b1;
            end
            MEM_WB: begin
                w.mem_to_reg = 1'b1;
                w.reg_write  = 1'b1;
                w.retire     = 1'b1;
            end
            EXECUTE: begin
                w.alu_src_a = 1'b1;
                w.alu_src_b = c_srcb_reg;
                w.alu_op    = c_aluop_funct;
            end
            ALU_WB: begin
                w.reg_dst   = 1'b1;
                w.reg_write = 1'b1;
                w.retire    = 1'b1;
            end
            IMM_EXEC: begin
                w.alu_src_a = 1'b1;
                w.alu_src_b = c_srcb_imm;
                w.alu_op    = (k == OPK_ADDI) ? c_aluop_add : c_aluop_logic;
                w.imm_zext  = (k != OPK_ADDI);
            end
            IMM_WB: begin
                w.reg_write = 1'b1;
                w.retire    = 1'b1;
            end
            BRANCH: begin
                w.alu_src_a = 1'b1;
                w.alu_src_b = c_srcb_reg;
                w.alu_op    = c_aluop_sub;
                w.pc_src    = c_pcsrc_aluout;
                w.branch    = (k == OPK_BEQ);
                w.branch_ne = (k == OPK_BNE);
                w.retire    = 1'b1;
            end
            JUMP: begin
                w.pc_src   = c_pcsrc_jump;
                w.pc_write = 1'b1;
                w.retire   = 1'b1;
            end
            JAL_LINK: begin
                w.link      = 1'b1;
                w.reg_write = 1'b1;
                w.pc_src    = c_pcsrc_jump;
                w.pc_write  = 1'b1;
                w.retire    = 1'b1;
            end
            default: begin
                w.fault = 1'b1;
            end
        endcase
        return w;
    endfunction

    localparam ctrl_word_t c_fetch_word = ctrl_decode(FETCH, OPK_RTYPE);

    state_t     r_state;
    state_t     w_next;
    ctrl_word_t r_ctrl;
    ctrl_word_t w_ctrl_next;
    op_kind_t   w_kind;
    logic       w_in_mem;
    logic       w_wait_inc;
    logic       w_timer_clr;
    logic       w_timeout;
    logic       w_gate_ok;
    logic       w_en_ok;

    assign w_kind      = decode_op(6'(op_i6));
    assign w_in_mem    = (r_state == FETCH) || (r_state == MEM_READ) || (r_state == MEM_WRITE);
    assign w_wait_inc  = w_in_mem && !mem_ready_i;
    assign w_timer_clr = (w_next != r_state);

    mc_wait_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst     (reset_i),
        .clr     (w_timer_clr),
        .inc     (w_wait_inc),
        .timeout (w_timeout)
    );

    // Ready is tested before timeout so a last-moment completion still succeeds.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH: begin
                if (mem_ready_i)    w_next = DECODE;
                else if (w_timeout) w_next = FAULT;
            end
            DECODE: begin
                case (w_kind)
                    OPK_LW, OPK_SW:             w_next = MEM_ADR;
                    OPK_RTYPE:                  w_next = EXECUTE;
                    OPK_BEQ, OPK_BNE:           w_next = BRANCH;
                    OPK_ADDI, OPK_ANDI, OPK_ORI: w_next = IMM_EXEC;
                    OPK_J:                      w_next = JUMP;
                    OPK_JAL:                    w_next = JAL_LINK;
                    default:                    w_next = (TRAP_ILLEGAL != 0) ? FAULT : FETCH;
                endcase
            end
            MEM_ADR:   w_next = (w_kind == OPK_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ: begin
                if (mem_ready_i)    w_next = MEM_WB;
                else if (w_timeout) w_next = FAULT;
            end
            MEM_WRITE: begin
                if (mem_ready_i)    w_next = FETCH;
                else if (w_timeout) w_next = FAULT;
            end
            MEM_WB, ALU_WB, IMM_WB, BRANCH, JUMP, JAL_LINK: w_next = FETCH;
            EXECUTE:   w_next = ALU_WB;
            IMM_EXEC:  w_next = IMM_WB;
            default:   w_next = FAULT;
        endcase
    end

    always_comb begin
        w_ctrl_next = ctrl_decode(w_next, w_kind);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= FETCH;
            r_ctrl  <= c_fetch_word;
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    assign w_gate_ok = !r_ctrl.rdy_gate || mem_ready_i;
    assign w_en_ok   = !reset_i;

    assign mem_req_o       = r_ctrl.mem_req;
    assign mem_to_reg_o    = r_ctrl.mem_to_reg;
    assign reg_dst_rtrd_o  = r_ctrl.reg_dst;
    assign instr_or_data_o = r_ctrl.iord;
    assign a_alu_input_o   = r_ctrl.alu_src_a;
    assign pc_branch_o2    = r_ctrl.pc_src;
    assign b_alu_input_o2  = r_ctrl.alu_src_b;
    assign alu_alt_ctrl_o2 = r_ctrl.alu_op;
    assign instr_we_o      = r_ctrl.ir_write  && w_gate_ok && w_en_ok;
    assign pc_write_o      = r_ctrl.pc_write  && w_gate_ok && w_en_ok;
    assign retire_o        = r_ctrl.retire    && w_gate_ok && w_en_ok;
    assign enable_wmem_o   = r_ctrl.mem_write && w_en_ok;
    assign enable_wrf_o    = r_ctrl.reg_write && w_en_ok;
    assign branch_o        = r_ctrl.branch;
    assign branch_ne_o     = r_ctrl.branch_ne;
    assign imm_zext_o      = r_ctrl.imm_zext;
    assign link_o          = r_ctrl.link;
    assign fault_o         = r_ctrl.fault;
    assign state_o4        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller_fsm.sv
// ============================================================================
// Module : tb_mc_controller_fsm
// Brief  : Directed self-checking bench for mc_controller_fsm (trapping and
//          non-trapping instances, 4-cycle timeout).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_controller_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [5:0] op;

    logic       mem_req, mem_to_reg, reg_dst, iord, srca;
    logic [1:0] pcsrc, srcb, aluop;
    logic       irw, wmem, pcw, wrf, br, brne, zext, link, retire, fault;
    logic [3:0] state;

    logic       n_mem_req, n_mem_to_reg, n_reg_dst, n_iord, n_srca;
    logic [1:0] n_pcsrc, n_srcb, n_aluop;
    logic       n_irw, n_wmem, n_pcw, n_wrf, n_br, n_brne, n_zext, n_link, n_retire, n_fault;
    logic [3:0] n_state;

    int compared   = 0;
    int mismatched = 0;
    int n_ir       = 0;
    int n_ret      = 0;

    always #5 clk = ~clk;

    mc_controller_fsm #(.OP_W(6), .TIMEOUT_CYC(4), .TRAP_ILLEGAL(1)) dut (
        .clk_i(clk), .reset_i(reset), .op_i6(op), .mem_ready_i(ready),
        .mem_req_o(mem_req), .mem_to_reg_o(mem_to_reg), .reg_dst_rtrd_o(reg_dst),
        .instr_or_data_o(iord), .a_alu_input_o(srca), .pc_branch_o2(pcsrc),
        .b_alu_input_o2(srcb), .alu_alt_ctrl_o2(aluop), .instr_we_o(irw),
        .enable_wmem_o(wmem), .pc_write_o(pcw), .enable_wrf_o(wrf),
        .branch_o(br), .branch_ne_o(brne), .imm_zext_o(zext), .link_o(link),
        .retire_o(retire), .fault_o(fault), .state_o4(state)
    );

    mc_controller_fsm #(.OP_W(6), .TIMEOUT_CYC(4), .TRAP_ILLEGAL(0)) dut_nt (
        .clk_i(clk), .reset_i(reset), .op_i6(op), .mem_ready_i(ready),
        .mem_req_o(n_mem_req), .mem_to_reg_o(n_mem_to_reg), .reg_dst_rtrd_o(n_reg_dst),
        .instr_or_data_o(n_iord), .a_alu_input_o(n_srca), .pc_branch_o2(n_pcsrc),
        .b_alu_input_o2(n_srcb), .alu_alt_ctrl_o2(n_aluop), .instr_we_o(n_irw),
        .enable_wmem_o(n_wmem), .pc_write_o(n_pcw), .enable_wrf_o(n_wrf),
        .branch_o(n_br), .branch_ne_o(n_brne), .imm_zext_o(n_zext), .link_o(n_link),
        .retire_o(n_retire), .fault_o(n_fault), .state_o4(n_state)
    );

    always @(posedge clk) begin
        if (!reset && irw)    n_ir  <= n_ir + 1;
        if (!reset && retire) n_ret <= n_ret + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy);
        @(negedge clk);
        ready = rdy;
        #1;
    endtask

    // Entered from FETCH: one ready FETCH cycle, then DECODE.
    task automatic fetch_decode(input logic [5:0] opc, input string tag);
        op = opc;
        cyc(1'b1);
        chk({tag, "_fetch_state"}, 8'(state), 8'd0);
        chk({tag, "_fetch_irw"},   8'(irw),   8'd1);
        cyc(1'b0);
        chk({tag, "_decode_state"}, 8'(state), 8'd1);
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b1;
        op    = 6'b000000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state",  8'(state),   8'd0);
        chk("rst_req",    8'(mem_req), 8'd1);
        chk("rst_irw",    8'(irw),     8'd0);
        chk("rst_pcw",    8'(pcw),     8'd0);
        chk("rst_wrf",    8'(wrf),     8'd0);
        chk("rst_wmem",   8'(wmem),    8'd0);
        chk("rst_retire", 8'(retire),  8'd0);
        chk("rst_fault",  8'(fault),   8'd0);

        // LW: ready on third FETCH cycle and first MEM_READ cycle
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b0;
        op    = 6'b100011;
        #1;
        chk("lw_f1_irw", 8'(irw), 8'd0);
        cyc(1'b0);
        chk("lw_f2_state", 8'(state), 8'd0);
        chk("lw_f2_irw",   8'(irw),   8'd0);
        cyc(1'b1);
        chk("lw_f3_state", 8'(state), 8'd0);
        chk("lw_f3_irw",   8'(irw),   8'd1);
        chk("lw_f3_pcw",   8'(pcw),   8'd1);
        chk("lw_f3_srcb",  8'(srcb),  8'd1);
        cyc(1'b0);
        chk("lw_dec_state", 8'(state), 8'd1);
        chk("lw_dec_srcb",  8'(srcb),  8'd3);
        cyc(1'b0);
        chk("lw_adr_state", 8'(state), 8'd2);
        chk("lw_adr_srca",  8'(srca),  8'd1);
        chk("lw_adr_srcb",  8'(srcb),  8'd2);
        cyc(1'b1);
        chk("lw_rd_state", 8'(state),   8'd3);
        chk("lw_rd_iord",  8'(iord),    8'd1);
        chk("lw_rd_req",   8'(mem_req), 8'd1);
        cyc(1'b0);
        chk("lw_wb_state",  8'(state),      8'd4);
        chk("lw_wb_wrf",    8'(wrf),        8'd1);
        chk("lw_wb_m2r",    8'(mem_to_reg), 8'd1);
        chk("lw_wb_retire", 8'(retire),     8'd1);
        cyc(1'b0);
        chk("lw_end_state", 8'(state), 8'd0);
        chk("lw_ir_pulses", 8'(n_ir),  8'd1);
        chk("lw_retires",   8'(n_ret), 8'd1);

        // SW: two wait cycles in MEM_WRITE, ready on the third
        fetch_decode(6'b101011, "sw");
        cyc(1'b0);
        chk("sw_adr_state", 8'(state), 8'd2);
        cyc(1'b0);
        chk("sw_w1_state",  8'(state),  8'd5);
        chk("sw_w1_wmem",   8'(wmem),   8'd1);
        chk("sw_w1_retire", 8'(retire), 8'd0);
        cyc(1'b0);
        chk("sw_w2_wmem",   8'(wmem),   8'd1);
        chk("sw_w2_retire", 8'(retire), 8'd0);
        cyc(1'b1);
        chk("sw_w3_state",  8'(state),  8'd5);
        chk("sw_w3_wmem",   8'(wmem),   8'd1);
        chk("sw_w3_retire", 8'(retire), 8'd1);
        cyc(1'b0);
        chk("sw_end_state", 8'(state), 8'd0);
        chk("sw_end_wmem",  8'(wmem),  8'd0);
        chk("sw_retires",   8'(n_ret), 8'd2);

        fetch_decode(6'b000101, "bne");
        cyc(1'b0);
        chk("bne_state",  8'(state),  8'd10);
        chk("bne_brne",   8'(brne),   8'd1);
        chk("bne_br",     8'(br),     8'd0);
        chk("bne_aluop",  8'(aluop),  8'd1);
        chk("bne_pcsrc",  8'(pcsrc),  8'd1);
        chk("bne_retire", 8'(retire), 8'd1);
        cyc(1'b0);

        fetch_decode(6'b000100, "beq");
        cyc(1'b0);
        chk("beq_state", 8'(state), 8'd10);
        chk("beq_br",    8'(br),    8'd1);
        chk("beq_brne",  8'(brne),  8'd0);
        cyc(1'b0);
        chk("beq_end_state", 8'(state), 8'd0);

        fetch_decode(6'b001101, "ori");
        cyc(1'b0);
        chk("ori_ex_state", 8'(state), 8'd8);
        chk("ori_ex_aluop", 8'(aluop), 8'd3);
        chk("ori_ex_zext",  8'(zext),  8'd1);
        chk("ori_ex_srcb",  8'(srcb),  8'd2);
        cyc(1'b0);
        chk("ori_wb_state",  8'(state),   8'd9);
        chk("ori_wb_wrf",    8'(wrf),     8'd1);
        chk("ori_wb_regdst", 8'(reg_dst), 8'd0);
        chk("ori_wb_retire", 8'(retire),  8'd1);
        cyc(1'b0);

        fetch_decode(6'b000011, "jal");
        cyc(1'b0);
        chk("jal_state", 8'(state), 8'd12);
        chk("jal_link",  8'(link),  8'd1);
        chk("jal_wrf",   8'(wrf),   8'd1);
        chk("jal_pcw",   8'(pcw),   8'd1);
        chk("jal_pcsrc", 8'(pcsrc), 8'd2);
        cyc(1'b0);

        // ADDI interrupted by reset in IMM_EXEC
        fetch_decode(6'b001000, "addi");
        cyc(1'b0);
        chk("addi_ex_state", 8'(state), 8'd8);
        chk("addi_ex_aluop", 8'(aluop), 8'd0);
        chk("addi_ex_zext",  8'(zext),  8'd0);
        reset = 1'b1;
        #1;
        chk("addi_rst_state", 8'(state),   8'd0);
        chk("addi_rst_wrf",   8'(wrf),     8'd0);
        chk("addi_rst_req",   8'(mem_req), 8'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("addi_post_state", 8'(state), 8'd0);
        chk("addi_post_wrf",   8'(wrf),   8'd0);

        // Ready on the last allowed FETCH wait cycle wins over timeout
        op = 6'b000010;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        chk("edge_f4_state", 8'(state), 8'd0);
        chk("edge_f4_irw",   8'(irw),   8'd1);
        cyc(1'b0);
        chk("edge_dec_state", 8'(state), 8'd1);
        cyc(1'b0);
        chk("j_state",  8'(state),  8'd11);
        chk("j_pcw",    8'(pcw),    8'd1);
        chk("j_pcsrc",  8'(pcsrc),  8'd2);
        chk("j_retire", 8'(retire), 8'd1);

        // Timeout: four FETCH cycles without ready
        cyc(1'b0);
        chk("to_f1_state", 8'(state), 8'd0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        chk("to_f4_state", 8'(state), 8'd0);
        cyc(1'b1);
        chk("to_state", 8'(state),   8'd13);
        chk("to_fault", 8'(fault),   8'd1);
        chk("to_req",   8'(mem_req), 8'd0);
        chk("to_irw",   8'(irw),     8'd0);
        chk("to_pcw",   8'(pcw),     8'd0);
        cyc(1'b0);
        chk("to_hold_state", 8'(state), 8'd13);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("to_rst_state", 8'(state),   8'd0);
        chk("to_rst_fault", 8'(fault),   8'd0);
        chk("to_rst_req",   8'(mem_req), 8'd1);

        // Undefined opcode on both trap settings
        fetch_decode(6'b111111, "ill");
        cyc(1'b0);
        chk("ill_trap_state", 8'(state),     8'd13);
        chk("ill_trap_fault", 8'(fault),     8'd1);
        chk("ill_nop_state",  8'(n_state),   8'd0);
        chk("ill_nop_fault",  8'(n_fault),   8'd0);
        chk("ill_nop_irw",    8'(n_irw),     8'd0);
        chk("ill_nop_pcw",    8'(n_pcw),     8'd0);
        chk("ill_nop_wrf",    8'(n_wrf),     8'd0);
        chk("ill_nop_req",    8'(n_mem_req), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
